inst_prefetcher: RTL
====================

// Module: inst_prefetcher
// PURPOSE
// Next-line instruction prefetcher feeding the cache top's prefetch2Icache_* request port.
// On an Icache demand miss it streams up to DEPTH sequential 8-byte line addresses.
// It consumes the cache's prefetch grant and MSHR_full and observes fill returns.
// A small recent-line filter suppresses duplicate requests.
// PARAMETERS
// DEPTH         4   lines prefetched per trigger (1..15)
// FILTER_SIZE   4   entries in the recent-line filter (power of 2, >=2)
// PORTS
// clock                   in   1   system clock
// reset                   in   1   asynchronous, active-high reset
// proc2Icache_addr        in   64  demand fetch address
// proc2Icache_request     in   1   demand fetch valid
// Icache2proc_valid_outA  in   1   demand hit this cycle
// Icache2proc_valid_outB  in   1   fill data returned from memory this cycle
// Icache2proc_addr_outB   in   64  address of the returned fill
// Icache2prefetch_grant   in   1   cache accepted the prefetch request this cycle
// MSHR_full               in   1   no MSHR free; hold requests
// branch_recovery         in   1   squash the prefetch stream
// prefetch2Icache_addr    out  64  prefetch line address, bits[2:0]=0
// prefetch2Icache_request out  1   prefetch request valid
// prefetch_busy           out  1   state==ISSUE
// prefetch_issued_cnt     out  16  count of granted prefetches; wraps at 2^16
// BEHAVIOUR
// - Reset: state=IDLE, next_addr=0, remaining=0, all filter entries invalid, fill pointer 0.
//   All outputs 0.
// - line(a) = {a[63:3],3'b0}. Address add is modulo 2^64; wrap past 64'hFFFF_FFFF_FFFF_FFF8 goes to 0.
// - miss = proc2Icache_request & ~Icache2proc_valid_outA.
// - States: IDLE and ISSUE.
//   - IDLE, on miss: next_addr=line(addr)+8, win_base=next_addr, remaining=DEPTH; go to ISSUE next cycle.
//   - ISSUE, on miss: if line(addr) is outside [win_base, win_base+8*DEPTH), restart as from IDLE.
//     Otherwise ignore the miss.
// - filt_hit = next_addr matches a valid filter entry.
// - Request is combinational from registered state:
//   prefetch2Icache_request = ISSUE & ~MSHR_full & ~filt_hit.
//   prefetch2Icache_addr = next_addr.
// - Request/grant: request and address hold stable until granted. A grant while request=0 is ignored.
// - On grant: next_addr+=8, remaining-=1, prefetch_issued_cnt+=1, insert next_addr into filter.
// - ISSUE & filt_hit & ~MSHR_full: skip the line. next_addr+=8, remaining-=1, no request, no count.
//   One line is skipped per cycle.
// - MSHR_full in ISSUE: hold all state, request=0 (skip logic also stalls).
// - When remaining reaches 0, go to IDLE on the same edge.
// - Filter: FIFO replacement by wrapping pointer. An Icache2proc_valid_outB fill inserts line(addr_outB).
//   - Grant and fill in the same cycle: grant line goes to slot ptr, fill line to ptr+1, ptr+=2.
//   - An insert of a line already present is dropped; the pointer does not advance for it.
// - branch_recovery has highest priority: state=IDLE, remaining=0, request deasserted next cycle.
//   - A same-cycle miss or grant is ignored (grant does not count or insert).
//   - Filter contents are retained.
// - Restart in the same cycle as a grant: the grant is counted and inserted, then the new window is loaded.
// - Reset asserted mid-stream clears everything immediately (asynchronous).
// TESTING
// - Miss @64'h1000, MSHR_full=0, grant every cycle:
//   requests 1008,1010,1018,1020 on consecutive cycles; cnt=4; IDLE; busy low.
// - Same start, MSHR_full=1 for 3 cycles after the first grant:
//   request low and addr held at 1010 for 3 cycles, then resumes; total 4 grants.
// - Fill valid_outB with addr 1010, then miss @1000: 1010 is skipped.
//   Requests are 1008,1018,1020 only; cnt=3.
// - Miss @2000 streaming, then miss @2010 (inside window): no restart.
//   Then miss @8000: next request is 8008 with remaining=4.
// - branch_recovery coincident with a grant of 1010:
//   next cycle request=0, IDLE, cnt unchanged, 1010 not in filter.
// - Miss @64'hFFFF_FFFF_FFFF_FFF0, DEPTH=4: requests ...FFF8, 0, 8, 10 (wrap).
//   Async reset mid-stream drops request within the same cycle.

Source files
------------

// File: rtl/inst_prefetcher_if.sv
// Request/grant bundle between the instruction prefetcher and the Icache top.
// The prefetcher takes the master modport; the cache side takes the slave modport.
interface inst_prefetcher_if;
    logic [63:0] proc2Icache_addr;
    logic        proc2Icache_request;
    logic        Icache2proc_valid_outA;
    logic        Icache2proc_valid_outB;
    logic [63:0] Icache2proc_addr_outB;
    logic        Icache2prefetch_grant;
    logic        MSHR_full;
    logic        branch_recovery;
    logic [63:0] prefetch2Icache_addr;
    logic        prefetch2Icache_request;
    logic        prefetch_busy;
    logic [15:0] prefetch_issued_cnt;

    modport master (
        input  proc2Icache_addr, proc2Icache_request, Icache2proc_valid_outA,
               Icache2proc_valid_outB, Icache2proc_addr_outB, Icache2prefetch_grant,
               MSHR_full, branch_recovery,
        output prefetch2Icache_addr, prefetch2Icache_request, prefetch_busy,
               prefetch_issued_cnt
    );

    modport slave (
        output proc2Icache_addr, proc2Icache_request, Icache2proc_valid_outA,
               Icache2proc_valid_outB, Icache2proc_addr_outB, Icache2prefetch_grant,
               MSHR_full, branch_recovery,
        input  prefetch2Icache_addr, prefetch2Icache_request, prefetch_busy,
               prefetch_issued_cnt
    );
endinterface

// File: rtl/inst_prefetcher.sv
// Next-line instruction prefetcher: on a demand miss it streams DEPTH sequential 8-byte
// line addresses to the Icache, skipping lines held in a small FIFO recent-line filter.
module inst_prefetcher #(
    parameter int DEPTH       = 4,
    parameter int FILTER_SIZE = 4
) (
    input  logic               clock,
    input  logic               reset,
    inst_prefetcher_if.master  bus
);
    localparam int          PTR_W     = $clog2(FILTER_SIZE);
    localparam logic [63:0] WIN_BYTES = 64'(8 * DEPTH);
    localparam logic [3:0]  DEPTH_L   = 4'(DEPTH);

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t            state_reg;
    logic [63:0]       next_addr_reg;
    logic [63:0]       win_base_reg;
    logic [3:0]        remaining_reg;
    logic [15:0]       issued_cnt_reg;
    logic [63:0]       filt_line_reg [FILTER_SIZE];
    logic [FILTER_SIZE-1:0] filt_valid_reg;
    logic [PTR_W-1:0]  ptr_reg;

    logic [63:0]       miss_line;
    logic [63:0]       fill_line;
    logic [FILTER_SIZE-1:0] next_match;
    logic [FILTER_SIZE-1:0] fill_match;
    logic              filt_hit;
    logic              issuing;
    logic              miss;
    logic              request;
    logic              grant_take;
    logic              skip;
    logic              advance;
    logic              restart;
    logic              fill_ins;
    logic [PTR_W-1:0]  fill_slot;

    assign miss_line = {bus.proc2Icache_addr[63:3], 3'b000};
    assign fill_line = {bus.Icache2proc_addr_outB[63:3], 3'b000};

    // The slot a same-cycle grant overwrites no longer counts as holding the fill line.
    generate
        for (genvar gi = 0; gi < FILTER_SIZE; gi++) begin : g_filt_cmp
            assign next_match[gi] = filt_valid_reg[gi] && (filt_line_reg[gi] == next_addr_reg);
            assign fill_match[gi] = filt_valid_reg[gi] && (filt_line_reg[gi] == fill_line) &&
                                    !(grant_take && (ptr_reg == PTR_W'(gi)));
        end
    endgenerate

    assign filt_hit   = |next_match;
    assign issuing    = (state_reg == ISSUE);
    assign miss       = bus.proc2Icache_request & ~bus.Icache2proc_valid_outA;
    assign request    = issuing & ~bus.MSHR_full & ~filt_hit;
    assign grant_take = request & bus.Icache2prefetch_grant & ~bus.branch_recovery;
    assign skip       = issuing & filt_hit & ~bus.MSHR_full & ~bus.branch_recovery;
    assign advance    = grant_take | skip;

    // Modular distance handles windows that wrap past the top of the address space.
    assign restart  = miss & ~bus.branch_recovery &
                      (~issuing | ((miss_line - win_base_reg) >= WIN_BYTES));
    assign fill_ins = bus.Icache2proc_valid_outB & ~(|fill_match) &
                      ~(grant_take & (fill_line == next_addr_reg));
    assign fill_slot = ptr_reg + PTR_W'(grant_take);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            next_addr_reg  <= '0;
            win_base_reg   <= '0;
            remaining_reg  <= '0;
            issued_cnt_reg <= '0;
            filt_valid_reg <= '0;
            ptr_reg        <= '0;
            for (int i = 0; i < FILTER_SIZE; i++) begin
                filt_line_reg[i] <= '0;
            end
        end else begin
            if (bus.branch_recovery) begin
                state_reg     <= IDLE;
                remaining_reg <= '0;
            end else if (restart) begin
                next_addr_reg <= miss_line + 64'd8;
                win_base_reg  <= miss_line + 64'd8;
                remaining_reg <= DEPTH_L;
                state_reg     <= ISSUE;
            end else if (advance) begin
                next_addr_reg <= next_addr_reg + 64'd8;
                remaining_reg <= remaining_reg - 4'd1;
                if (remaining_reg == 4'd1) begin
                    state_reg <= IDLE;
                end
            end

            if (grant_take) begin
                issued_cnt_reg          <= issued_cnt_reg + 16'd1;
                filt_line_reg[ptr_reg]  <= next_addr_reg;
                filt_valid_reg[ptr_reg] <= 1'b1;
            end
            if (fill_ins) begin
                filt_line_reg[fill_slot]  <= fill_line;
                filt_valid_reg[fill_slot] <= 1'b1;
            end
            ptr_reg <= ptr_reg + PTR_W'(grant_take) + PTR_W'(fill_ins);
        end
    end

    assign bus.prefetch2Icache_request = request;
    assign bus.prefetch2Icache_addr    = next_addr_reg;
    assign bus.prefetch_busy           = issuing;
    assign bus.prefetch_issued_cnt     = issued_cnt_reg;
endmodule
